// File: rtl/light_sensor_pkg.sv
// Shared types and default constants for the light sensor conditioner.
package light_sensor_pkg;

  // Bit 1 of the encoding marks the "lights on" states, so light_sensor
  // can come straight off a single flop without a decode glitch.
  typedef enum logic [1:0] {
    ST_DAY      = 2'b00,
    ST_DUSK_CHK = 2'b01,
    ST_NIGHT    = 2'b10,
    ST_DAWN_CHK = 2'b11
  } light_state_t;

  localparam logic [9:0]  DEF_DARK_THR      = 10'd300;
  localparam logic [9:0]  DEF_BRIGHT_THR    = 10'd400;
  localparam int unsigned DEF_CONFIRM_CNT   = 8;
  localparam logic [19:0] DEF_FAULT_TIMEOUT = 20'd1000000;
  localparam logic [9:0]  WINDOW_RESET      = 10'h3FF;

  function automatic logic state_is_night(light_state_t s);
    return s[1];
  endfunction

endpackage

// File: rtl/light_avg4.sv
// Four-sample moving average of the ADC stream.
// The window is the incoming sample plus the three most recent stored
// samples; only those three need flops because the oldest one is dropped
// at the same edge the new one arrives.
module light_avg4
  import light_sensor_pkg::*;
(
  input  logic       clk_in,
  input  logic       reset,
  input  logic       adc_valid,
  input  logic [9:0] adc_data,
  output logic [9:0] level_avg,
  output logic       avg_vld
);

  logic [2:0][9:0] hist;
  logic [11:0]     sum_next;

  // Sum of the window as it will look after this sample is shifted in.
  always_comb begin
    sum_next = 12'(adc_data) + 12'(hist[0]) + 12'(hist[1]) + 12'(hist[2]);
  end

  // Shift the window and register the new average on every valid sample.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      hist      <= {3{WINDOW_RESET}};
      level_avg <= WINDOW_RESET;
      avg_vld   <= 1'b0;
    end else begin
      avg_vld <= adc_valid;
      if (adc_valid) begin
        hist[0]   <= adc_data;
        hist[1]   <= hist[0];
        hist[2]   <= hist[1];
        level_avg <= sum_next[11:2];
      end
    end
  end

endmodule

// File: rtl/light_sensor_conditioner.sv
// Day/night conditioner: averages the light sensor, applies hysteresis
// plus a consecutive-sample confirmation, and fails safe (lights on) when
// the ADC stream stops.
//
//   state    | meaning
//   ---------+-------------------------------------------------
//   DAY      | lights off, watching for averages below DARK_THR
//   DUSK_CHK | lights off, counting consecutive dark averages
//   NIGHT    | lights on, watching for averages above BRIGHT_THR
//   DAWN_CHK | lights on, counting consecutive bright averages
module light_sensor_conditioner
  import light_sensor_pkg::*;
#(
  parameter logic [9:0]  DARK_THR      = DEF_DARK_THR,
  parameter logic [9:0]  BRIGHT_THR    = DEF_BRIGHT_THR,
  parameter int unsigned CONFIRM_CNT   = DEF_CONFIRM_CNT,
  parameter logic [19:0] FAULT_TIMEOUT = DEF_FAULT_TIMEOUT
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       adc_valid,
  input  logic [9:0] adc_data,
  output logic       light_sensor,
  output logic       sensor_fault,
  output logic [9:0] level_avg
);

  if (DARK_THR >= BRIGHT_THR) begin : g_thr_check
    $error("light_sensor_conditioner: DARK_THR must be below BRIGHT_THR");
  end
  if (CONFIRM_CNT < 1 || CONFIRM_CNT > 255) begin : g_cnt_check
    $error("light_sensor_conditioner: CONFIRM_CNT must be in 1..255");
  end

  localparam logic [7:0] CONFIRM_TGT = 8'(CONFIRM_CNT);

  logic [9:0]   avg;
  logic         avg_vld;
  light_state_t state, state_nxt;
  logic [7:0]   cnt, cnt_nxt, cnt_inc;
  logic [19:0]  to_cnt, to_nxt;
  logic         fault;
  logic         is_dark, is_bright;

  light_avg4 u_avg (
    .clk_in    (clk_in),
    .reset     (reset),
    .adc_valid (adc_valid),
    .adc_data  (adc_data),
    .level_avg (avg),
    .avg_vld   (avg_vld)
  );

  // Timeout counter: cleared by every sample, otherwise climbs and parks
  // at FAULT_TIMEOUT.
  always_comb begin
    to_nxt = to_cnt;
    if (adc_valid) begin
      to_nxt = '0;
    end else if (to_cnt != FAULT_TIMEOUT) begin
      to_nxt = to_cnt + 20'd1;
    end
  end

  // Register the timeout count and the fault flag derived from it.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
      fault  <= 1'b0;
    end else begin
      to_cnt <= to_nxt;
      fault  <= (to_nxt == FAULT_TIMEOUT);
    end
  end

  assign is_dark   = (avg < DARK_THR);
  assign is_bright = (avg > BRIGHT_THR);
  assign cnt_inc   = cnt + 8'd1;

  // Next state and confirm count; only a fresh average moves the FSM, and a
  // fault freezes it. Entering a CHK state already counts as one qualifying
  // sample, so CONFIRM_CNT=1 jumps straight across.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (avg_vld && !fault) begin
      unique case (state)
        ST_DAY, ST_DUSK_CHK: begin
          if (is_dark) begin
            if (cnt_inc == CONFIRM_TGT) begin
              state_nxt = ST_NIGHT;
              cnt_nxt   = '0;
            end else begin
              state_nxt = ST_DUSK_CHK;
              cnt_nxt   = cnt_inc;
            end
          end else begin
            state_nxt = ST_DAY;
            cnt_nxt   = '0;
          end
        end
        ST_NIGHT, ST_DAWN_CHK: begin
          if (is_bright) begin
            if (cnt_inc == CONFIRM_TGT) begin
              state_nxt = ST_DAY;
              cnt_nxt   = '0;
            end else begin
              state_nxt = ST_DAWN_CHK;
              cnt_nxt   = cnt_inc;
            end
          end else begin
            state_nxt = ST_NIGHT;
            cnt_nxt   = '0;
          end
        end
      endcase
    end
  end

  // State and confirm-count registers.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state <= ST_DAY;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign light_sensor = state_is_night(state) | fault;
  assign sensor_fault = fault;
  assign level_avg    = avg;

endmodule
